// File: rtl/serial_priority_encoder_if.sv
// Request/index handshake bundle for serial_priority_encoder.
// The master drives the controls and the request vector; the slave (encoder) returns the index stream.
interface serial_priority_encoder_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             ready;
  logic             valid;
  logic [IDX_W-1:0] idx;
  logic             busy;
  logic             done;

  modport master (
    output enable, load, d, ready,
    input  valid, idx, busy, done
  );

  modport slave (
    input  enable, load, d, ready,
    output valid, idx, busy, done
  );
endinterface

// File: rtl/serial_priority_encoder.sv
// Captures a request vector and emits the index of each set bit, highest first, one per handshake.
// Optional feature macro: LOAD_MERGE_EN (OR a Load received while busy into the pending set).
module serial_priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  serial_priority_encoder_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] merge_bits;
  logic [IDX_W-1:0] top_idx;
  logic             hs;

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_reg[i]) top_idx = IDX_W'(i);
    end
  end

  assign hs = (state_reg == BUSY) & bus.ready & bus.enable;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_clear
      assign clear_mask[gi] = hs && (top_idx == IDX_W'(gi));
    end
  endgenerate

`ifdef LOAD_MERGE_EN
  assign merge_bits = bus.load ? bus.d : '0;
`else
  assign merge_bits = '0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      done_reg    <= 1'b0;
    end else if (bus.enable) begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
    end else begin
      // A frozen cycle must not stretch a Done pulse once Enable returns.
      done_reg    <= 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          if (bus.d != '0) begin
            pending_next = bus.d;
            state_next   = BUSY;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      BUSY: begin
        // Handshake clear is applied before any merged bits are added.
        pending_next = (pending_reg & ~clear_mask) | merge_bits;
        if (pending_next == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    bus.valid = (state_reg == BUSY);
    bus.busy  = (state_reg == BUSY);
    bus.idx   = (state_reg == BUSY) ? top_idx : '0;
    bus.done  = done_reg & bus.enable;
  end
endmodule

// File: tb/tb_serial_priority_encoder.sv
// Bench for serial_priority_encoder: directed scenarios plus random traffic against a queue-based model.
module tb_serial_priority_encoder;
  logic clock;
  logic resetn;

  serial_priority_encoder_if #(.WIDTH(8)) bus ();

  serial_priority_encoder #(.WIDTH(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;

  // Reference model: outstanding request indices in emission order, plus a Done flag.
  int m_q[$];
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_from_mask(input logic [7:0] m);
    m_q.delete();
    for (int i = 7; i >= 0; i--) if (m[i]) m_q.push_back(i);
  endtask

  task automatic check_all();
    int exp_idx;
    exp_idx = (m_q.size() > 0) ? m_q[0] : 0;
    chk("valid", {31'd0, bus.valid}, {31'd0, m_q.size() > 0});
    chk("busy",  {31'd0, bus.busy},  {31'd0, m_q.size() > 0});
    chk("idx",   {29'd0, bus.idx},   exp_idx);
    chk("done",  {31'd0, bus.done},  {31'd0, m_done & bus.enable});
  endtask

  task automatic model_update(input bit en, input bit ld, input logic [7:0] dv, input bit rdy);
    logic [7:0] mask;
    bit new_done;
    if (!en) begin
      m_done = 1'b0;
      return;
    end
    new_done = 1'b0;
    if (m_q.size() == 0) begin
      if (ld) begin
        if (dv == 8'h00) new_done = 1'b1;
        else fill_from_mask(dv);
      end
    end else begin
      if (rdy) void'(m_q.pop_front());
`ifdef LOAD_MERGE_EN
      if (ld) begin
        mask = dv;
        foreach (m_q[k]) mask[m_q[k]] = 1'b1;
        fill_from_mask(mask);
      end
`else
      mask = 8'h00;
`endif
      if (m_q.size() == 0) new_done = 1'b1;
    end
    m_done = new_done;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input bit en, input bit ld, input logic [7:0] dv, input bit rdy);
    @(negedge clock);
    bus.enable = en;
    bus.load   = ld;
    bus.d      = dv;
    bus.ready  = rdy;
    #1;
    check_all();
    @(posedge clock);
    model_update(en, ld, dv, rdy);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_idx",   {29'd0, bus.idx},   32'd0);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    m_q.delete();
    m_done = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_done      = 1'b0;
    bus.enable  = 1'b0;
    bus.load    = 1'b0;
    bus.d       = 8'h00;
    bus.ready   = 1'b0;
    resetn      = 1'b0;
    #1;
    chk("por_valid", {31'd0, bus.valid}, 32'd0);
    chk("por_idx",   {29'd0, bus.idx},   32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Burst 0x25: indices 5,2,0 back to back, then Done.
    step(1, 1, 8'h25, 1);
    #2 chk("burst_i5", {29'd0, bus.idx}, 32'd5);
    step(1, 0, 8'h00, 1);
    #2 chk("burst_i2", {29'd0, bus.idx}, 32'd2);
    step(1, 0, 8'h00, 1);
    #2 chk("burst_i0", {29'd0, bus.idx}, 32'd0);
    chk("burst_v0", {31'd0, bus.valid}, 32'd1);
    step(1, 0, 8'h00, 1);
    #2 chk("burst_done", {31'd0, bus.done}, 32'd1);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);

    // Backpressure on 0x81.
    step(1, 1, 8'h81, 0);
    repeat (3) step(1, 0, 8'h00, 0);
    #2 chk("bp_i7", {29'd0, bus.idx}, 32'd7);
    step(1, 0, 8'h00, 1);
    #2 chk("bp_i0", {29'd0, bus.idx}, 32'd0);
    repeat (3) step(1, 0, 8'h00, 1);

    // Empty load.
    step(1, 1, 8'h00, 0);
    #2 chk("empty_done", {31'd0, bus.done}, 32'd1);
    repeat (2) step(1, 0, 8'h00, 0);

    // Freeze after the first handshake of 0x0E.
    step(1, 1, 8'h0E, 1);
    step(1, 0, 8'h00, 1);
    repeat (3) step(0, 1, 8'hFF, 1);
    #2 chk("frz_i2", {29'd0, bus.idx}, 32'd2);
    repeat (4) step(1, 0, 8'h00, 1);

    // Load while busy: merged or dropped depending on the build.
    step(1, 1, 8'h05, 0);
    step(1, 1, 8'h80, 0);
`ifdef LOAD_MERGE_EN
    #2 chk("merge_i7", {29'd0, bus.idx}, 32'd7);
`else
    #2 chk("nomerge_i2", {29'd0, bus.idx}, 32'd2);
`endif
    repeat (5) step(1, 0, 8'h00, 1);

    // Reset mid-burst on 0x24; no Done afterwards.
    step(1, 1, 8'h24, 0);
    step(1, 0, 8'h00, 0);
    async_reset();
    repeat (3) step(1, 0, 8'h00, 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, rd, $urandom_range(0, 9) < 6);
    end
    step(1, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
